// File: rtl/fp_mul_sequencer_pkg.sv
// Shared types and widths for the FP multiply sequencer and its arbiter.
package fp_mul_pkg;
  localparam int MANT_W = 64;
  localparam int PROD_W = 128;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/fp_mul_sequencer_if.sv
// Reservation-station request bus and CDB result bus of the multiply sequencer.
interface fp_mul_sequencer_if
  import fp_mul_pkg::*;
#(
  parameter int NUM_RS = 3,
  parameter int TAG_W  = 4
);
  logic [NUM_RS-1:0]        req;
  logic [NUM_RS*TAG_W-1:0]  req_tag;
  logic [NUM_RS*MANT_W-1:0] req_a;
  logic [NUM_RS*MANT_W-1:0] req_b;
  logic [NUM_RS-1:0]        grant;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [PROD_W-1:0]        cdb_prod;
  logic                     cdb_ready;

  modport master (
    output req, req_tag, req_a, req_b, cdb_ready,
    input  grant, cdb_valid, cdb_tag, cdb_prod
  );

  modport slave (
    input  req, req_tag, req_a, req_b, cdb_ready,
    output grant, cdb_valid, cdb_tag, cdb_prod
  );
endinterface

// File: rtl/fp_mul_sequencer_rr_arbiter.sv
// Round-robin arbiter: first set request after ptr_i, wrapping; grant only when enabled.
module rr_arbiter #(
  parameter  int NUM_RS = 3,
  localparam int IDX_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
  input  logic [NUM_RS-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  input  logic              en_i,
  output logic [NUM_RS-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);
  always_comb begin
    int j;
    j       = 0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // Offsets 1..NUM_RS visit every station once, the last-served one last.
    for (int k = 1; k <= NUM_RS; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_RS) j = j - NUM_RS;
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(j);
      end
    end
    if (en_i && any_o) grant_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/fp_mul_sequencer.sv
// Issues one RS operand pair to the shared mantissa multiplier, holds it for
// LATENCY cycles, then offers the product on the CDB.
module fp_mul_sequencer
  import fp_mul_pkg::*;
#(
  parameter int NUM_RS  = 3,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  fp_mul_sequencer_if.slave      bus,
  output logic [MANT_W-1:0]      mul_a_o,
  output logic [MANT_W-1:0]      mul_b_o,
  input  logic [PROD_W-1:0]      mul_prod_i,
  output logic                   busy_o
);
  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [TAG_W-1:0]    tag_q;
  logic [TAG_W-1:0]    cdb_tag_q;
  logic [PROD_W-1:0]   cdb_prod_q;
  logic                cdb_valid_q;
  logic [MANT_W-1:0]   mul_a_q;
  logic [MANT_W-1:0]   mul_b_q;

  logic                issue_slot;
  logic                any_req;
  logic                do_issue;
  logic [IDX_W-1:0]    win_idx;
  logic [NUM_RS-1:0]   grant;
  logic [MANT_W-1:0]   mul_a_d;
  logic [MANT_W-1:0]   mul_b_d;
  logic [TAG_W-1:0]    tag_d;

  // Reset is folded in so grant stays low while the block is held in reset.
  assign issue_slot = !rst && !flush_i &&
                      ((state_q == IDLE) || ((state_q == DONE) && bus.cdb_ready));
  assign do_issue   = issue_slot && any_req;

  rr_arbiter #(.NUM_RS(NUM_RS)) u_arb (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .en_i    (issue_slot),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_req)
  );

  assign mul_a_d = bus.req_a[int'(win_idx)*MANT_W +: MANT_W];
  assign mul_b_d = bus.req_b[int'(win_idx)*MANT_W +: MANT_W];
  assign tag_d   = bus.req_tag[int'(win_idx)*TAG_W +: TAG_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= IDX_W'(NUM_RS - 1);
      tag_q       <= '0;
      cdb_tag_q   <= '0;
      cdb_prod_q  <= '0;
      cdb_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else if (flush_i) begin
      // Operand and product registers keep their contents; only control is killed.
      state_q     <= IDLE;
      cdb_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        BUSY: begin
          if (cnt_q == '0) begin
            cdb_prod_q  <= mul_prod_i;
            cdb_tag_q   <= tag_q;
            cdb_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.cdb_ready) begin
            cdb_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Issue only happens from IDLE or an accepted DONE, so it overrides the case.
      if (do_issue) begin
        mul_a_q  <= mul_a_d;
        mul_b_q  <= mul_b_d;
        tag_q    <= tag_d;
        rr_ptr_q <= win_idx;
        cnt_q    <= CNT_W'(LATENCY - 1);
        state_q  <= BUSY;
      end
    end
  end

  assign bus.grant     = grant;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_prod  = cdb_prod_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;
  assign busy_o        = (state_q != IDLE);
endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Directed and randomized bench for fp_mul_sequencer against a transaction-level model.
module tb_fp_mul_sequencer;
  import fp_mul_pkg::*;

  localparam int NUM_RS  = 3;
  localparam int TAG_W   = 4;
  localparam int LATENCY = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [MANT_W-1:0] mul_a;
  logic [MANT_W-1:0] mul_b;
  logic [PROD_W-1:0] mul_prod;
  logic              busy;

  fp_mul_sequencer_if #(.NUM_RS(NUM_RS), .TAG_W(TAG_W)) bus ();

  fp_mul_sequencer #(.NUM_RS(NUM_RS), .TAG_W(TAG_W), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .bus        (bus),
    .mul_a_o    (mul_a),
    .mul_b_o    (mul_b),
    .mul_prod_i (mul_prod),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Multicycle multiplier: output is only correct once inputs have settled LATENCY-1 edges.
  int stab = 0;
  always @(posedge clk) begin
    if (bus.grant != '0) stab <= 0;
    else if (stab < 1000) stab <= stab + 1;
  end
  assign mul_prod = (stab >= LATENCY - 1) ? (PROD_W'(mul_a) * PROD_W'(mul_b))
                                          : ~(PROD_W'(mul_a) * PROD_W'(mul_b));

  int errors = 0;
  int checks = 0;

  // Reference model state
  int                m_ptr;
  bit                m_idle;
  bit                m_res;
  int                m_left;
  logic [TAG_W-1:0]  m_tag, m_ptag;
  logic [PROD_W-1:0] m_prod, m_pprod;
  logic [MANT_W-1:0] m_a, m_b;

  task automatic chk(string tag, logic [PROD_W-1:0] obs, logic [PROD_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = NUM_RS - 1;
    m_idle = 1'b1;
    m_res  = 1'b0;
    m_left = 0;
    m_tag  = '0;
    m_ptag = '0;
    m_prod = '0;
    m_pprod = '0;
    m_a    = '0;
    m_b    = '0;
  endtask

  task automatic set_rs(int i, logic [TAG_W-1:0] t, logic [MANT_W-1:0] a, logic [MANT_W-1:0] b);
    bus.req_tag[i*TAG_W +: TAG_W]   = t;
    bus.req_a[i*MANT_W +: MANT_W]   = a;
    bus.req_b[i*MANT_W +: MANT_W]   = b;
  endtask

  function automatic logic [MANT_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock: check outputs against the model with the current inputs, advance the model, clock.
  task automatic cyc();
    logic [NUM_RS-1:0] eg;
    int  w;
    bit  iss;
    #1;
    iss = !flush && (m_idle || (m_res && bus.cdb_ready)) && (bus.req != '0);
    w   = -1;
    eg  = '0;
    if (iss) begin
      for (int k = 1; k <= NUM_RS; k++)
        if (w < 0 && bus.req[(m_ptr + k) % NUM_RS]) w = (m_ptr + k) % NUM_RS;
      eg[w] = 1'b1;
    end
    chk("grant", PROD_W'(bus.grant), PROD_W'(eg));
    chk("cdb_valid", PROD_W'(bus.cdb_valid), PROD_W'(m_res));
    chk("busy", PROD_W'(busy), PROD_W'(!m_idle));
    chk("mul_a", PROD_W'(mul_a), PROD_W'(m_a));
    chk("mul_b", PROD_W'(mul_b), PROD_W'(m_b));
    if (m_res) begin
      chk("cdb_tag", PROD_W'(bus.cdb_tag), PROD_W'(m_tag));
      chk("cdb_prod", bus.cdb_prod, m_prod);
    end
    if (flush) begin
      m_idle = 1'b1;
      m_res  = 1'b0;
    end else if (m_res) begin
      if (bus.cdb_ready) begin
        m_res  = 1'b0;
        m_idle = 1'b1;
      end
    end else if (!m_idle) begin
      m_left--;
      if (m_left == 0) begin
        m_res  = 1'b1;
        m_tag  = m_ptag;
        m_prod = m_pprod;
      end
    end
    if (iss) begin
      m_idle  = 1'b0;
      m_res   = 1'b0;
      m_left  = LATENCY;
      m_ptr   = w;
      m_a     = bus.req_a[w*MANT_W +: MANT_W];
      m_b     = bus.req_b[w*MANT_W +: MANT_W];
      m_ptag  = bus.req_tag[w*TAG_W +: TAG_W];
      m_pprod = PROD_W'(m_a) * PROD_W'(m_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_grant"}, PROD_W'(bus.grant), '0);
    chk({tag, "_mul_a"}, PROD_W'(mul_a), '0);
    chk({tag, "_mul_b"}, PROD_W'(mul_b), '0);
    chk({tag, "_cdb_valid"}, PROD_W'(bus.cdb_valid), '0);
    chk({tag, "_cdb_tag"}, PROD_W'(bus.cdb_tag), '0);
    chk({tag, "_cdb_prod"}, bus.cdb_prod, '0);
    chk({tag, "_busy"}, PROD_W'(busy), '0);
  endtask

  initial begin
    bus.req       = '0;
    bus.req_tag   = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.cdb_ready = 1'b0;
    flush         = 1'b0;
    rst           = 1'b0;
    #1 rst = 1'b1;
    #2;
    check_all_zero("reset");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request
    set_rs(0, 4'd5, 64'd3, 64'd7);
    bus.req       = 3'b001;
    bus.cdb_ready = 1'b1;
    cyc();
    bus.req = '0;
    chk("t1_mul_a", PROD_W'(mul_a), 128'd3);
    chk("t1_mul_b", PROD_W'(mul_b), 128'd7);
    repeat (LATENCY) cyc();
    chk("t1_valid", PROD_W'(bus.cdb_valid), 128'd1);
    chk("t1_prod", bus.cdb_prod, 128'd21);
    chk("t1_tag", PROD_W'(bus.cdb_tag), 128'd5);
    cyc();
    chk("t1_valid_fall", PROD_W'(bus.cdb_valid), 128'd0);

    // Fairness with all requests held
    for (int i = 0; i < NUM_RS; i++) set_rs(i, 4'($urandom), rnd64(), rnd64());
    bus.req = 3'b111;
    repeat (4 * (LATENCY + 1)) cyc();
    bus.req = '0;
    repeat (LATENCY + 3) cyc();

    // Backpressure in DONE
    set_rs(0, 4'($urandom), rnd64(), rnd64());
    bus.req       = 3'b001;
    bus.cdb_ready = 1'b0;
    cyc();
    bus.req = '0;
    repeat (LATENCY) cyc();
    set_rs(1, 4'($urandom), rnd64(), rnd64());
    bus.req = 3'b010;
    repeat (6) cyc();
    bus.cdb_ready = 1'b1;
    cyc();
    bus.req = '0;
    repeat (LATENCY + 3) cyc();

    // Flush while BUSY with counter at 2
    set_rs(2, 4'($urandom), rnd64(), rnd64());
    bus.req = 3'b100;
    cyc();
    bus.req = '0;
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (LATENCY + 2) cyc();
    set_rs(0, 4'($urandom), rnd64(), rnd64());
    bus.req = 3'b001;
    cyc();
    bus.req = '0;
    repeat (LATENCY + 2) cyc();

    // Flush colliding with DONE, ready and a pending request
    set_rs(1, 4'($urandom), rnd64(), rnd64());
    bus.req       = 3'b010;
    bus.cdb_ready = 1'b0;
    cyc();
    bus.req = '0;
    repeat (LATENCY + 1) cyc();
    set_rs(2, 4'($urandom), rnd64(), rnd64());
    bus.req       = 3'b100;
    bus.cdb_ready = 1'b1;
    flush         = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t5_busy", PROD_W'(busy), 128'd0);
    cyc();
    bus.req = '0;
    repeat (LATENCY + 2) cyc();

    // Async reset mid-BUSY, then maximum operands
    set_rs(0, 4'($urandom), rnd64(), rnd64());
    bus.req = 3'b001;
    cyc();
    cyc();
    #2 rst = 1'b1;
    #1;
    check_all_zero("areset");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.req = '0;
    set_rs(2, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.req = 3'b100;
    cyc();
    bus.req = '0;
    repeat (LATENCY) cyc();
    chk("t6_valid", PROD_W'(bus.cdb_valid), 128'd1);
    chk("t6_prod", bus.cdb_prod, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    cyc();

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NUM_RS; i++)
        if ($urandom_range(0, 3) == 0) set_rs(i, 4'($urandom), rnd64(), rnd64());
      bus.req       = NUM_RS'($urandom);
      bus.cdb_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      cyc();
    end
    bus.req       = '0;
    flush         = 1'b0;
    bus.cdb_ready = 1'b1;
    repeat (LATENCY + 3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mul_sequencer.md
Name: fp_mul_sequencer

Overview:
- Issue/sequencing controller for the shared 64x64 Wallace-tree mantissa multiplier in the FP multiply unit.
- Round-robin arbitrates among the multiply reservation stations and registers the winner's operands onto the multiplier inputs.
- Holds those operands stable for a multicycle window of LATENCY cycles, then captures the 128-bit product.
- Presents the product, with its reservation-station tag, to the CDB through a valid/ready handshake.

Parameters:
NUM_RS, 3, number of requesting reservation stations (>=2)
TAG_W, 4, reservation-station tag width
LATENCY, 4, cycles the multiplier inputs are held before the product is sampled (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of the in-flight and pending result
req  in  NUM_RS  per-RS request; held until granted or withdrawn
req_tag  in  NUM_RS*TAG_W  per-RS tag, packed, RS i at [i*TAG_W +: TAG_W]
req_a  in  NUM_RS*64  per-RS mantissa A, packed
req_b  in  NUM_RS*64  per-RS mantissa B, packed
grant  out  NUM_RS  one-hot, single-cycle pulse to the accepted RS
mul_a  out  64  registered operand to the multiplier
mul_b  out  64  registered operand to the multiplier
mul_prod  in  128  combinational product from the multiplier
cdb_valid  out  1  result valid
cdb_tag  out  TAG_W  tag of the result
cdb_prod  out  128  registered product
cdb_ready  in  1  CDB accepts the result this cycle
busy  out  1  high in BUSY or DONE

Behaviour:
- Reset (async, any state):
  - state=IDLE; all outputs 0 (grant, mul_a, mul_b, cdb_valid, cdb_tag, cdb_prod, busy).
  - Counter = 0; rr_ptr = NUM_RS-1, so RS0 has highest priority first.
- States: IDLE, BUSY, DONE.
- Arbitration:
  - Winner is the first set req bit scanning from rr_ptr+1 upward, wrapping modulo NUM_RS.
  - On a grant, rr_ptr <= winner index.
  - Grant is combinational from the current state, req, and flush. It is asserted only in "issue" cycles (defined below) and is 0 when flush=1.
- Issue cycle: (IDLE or (DONE and cdb_ready)) and |req and !flush. On the issue edge:
  - mul_a/mul_b <= winner operands; tag register <= winner tag.
  - Counter <= LATENCY-1; state <= BUSY.
- BUSY:
  - mul_a/mul_b hold constant.
  - Counter decrements each cycle while nonzero.
  - On the cycle counter==0: cdb_prod <= mul_prod, cdb_tag <= tag, cdb_valid <= 1, state <= DONE.
  - Latency from grant cycle to first cdb_valid cycle = LATENCY+1 edges. With LATENCY=1, cdb_valid rises 2 cycles after grant.
- DONE:
  - cdb_valid, cdb_tag, cdb_prod hold stable until cdb_ready=1.
  - If cdb_ready and an issue occurs the same cycle: back-to-back, cdb_valid <= 0, state <= BUSY.
  - If cdb_ready and no request: cdb_valid <= 0, state <= IDLE.
- flush (synchronous):
  - Any state: state <= IDLE, cdb_valid <= 0, no grant that cycle.
  - In-flight operation discarded; mul_a/mul_b/cdb_prod are not cleared.
  - flush outranks a simultaneous cdb_ready; the result is not counted as delivered.
- Boundary rules:
  - req withdrawn before grant is legal and ignored.
  - req bits for non-winners are unaffected by a grant.
  - All req set continuously: grants rotate 0,1,2,0,...
  - mul_prod is only sampled at counter==0.
  - busy = (state != IDLE).

Decomposition:
- Package fp_mul_pkg holds: state enum (IDLE/BUSY/DONE), MANT_W=64, PROD_W=128.
- One sub-module: rr_arbiter (NUM_RS-wide, inputs req/ptr/enable, outputs one-hot grant and winner index), reusable by other FU controllers.
- The multiplier itself is instantiated outside this block.

Test Plan:
1. Single request: req=3'b001, tag=5, a=3, b=7, LATENCY=4, cdb_ready=1 -> grant=001 for one cycle; mul_a=3, mul_b=7; cdb_valid after 5 edges with cdb_prod=21, cdb_tag=5, held 1 cycle.
2. Fairness: req=3'b111 held, cdb_ready=1 -> grant order 001,010,100,001; back-to-back issue in each DONE&ready cycle; no IDLE gaps.
3. Backpressure: result in DONE, cdb_ready=0 for 6 cycles, req=010 pending -> cdb_valid/tag/prod stable, no grant; ready=1 -> grant=010 same cycle, cdb_valid falls next edge.
4. Flush in BUSY: flush at counter=2 -> IDLE next cycle, no cdb_valid ever for that tag; next req is granted normally.
5. Flush collides with DONE&cdb_ready&req -> no grant, cdb_valid=0, state IDLE.
6. Async reset mid-BUSY, then max operands a=b=64'hFFFF_FFFF_FFFF_FFFF -> outputs 0 immediately without a clock; after re-issue, cdb_prod=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
